// File: rtl/accel_driver_pkg.sv
// ============================================================================
// Module      : accel_driver_pkg
// Description : Shared FSM encoding and emesh packet field layout.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package accel_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam int PKT_WRITE_BIT = 0;
    localparam int PKT_DMODE_LSB = 1;
    localparam int PKT_CMODE_LSB = 3;
    localparam int PKT_DST_LSB   = 8;
    localparam int PKT_DATA_LSB  = 40;
    localparam int PKT_SRC_LSB   = 72;

    localparam logic [1:0]  DATAMODE_WORD = 2'b10;
    localparam logic [4:0]  CTRLMODE_NONE = 5'd0;
    localparam logic [19:0] SRCADDR_LO    = 20'h0;

endpackage

`default_nettype wire

// File: rtl/accel_driver_if.sv
// ============================================================================
// Module      : accel_driver_if
// Description : Command/response handshake plus emesh write, read-request and
//               read-response channels. master = driver side.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface accel_driver_if #(
    parameter int AW = 32,
    parameter int PW = 2*AW+40
);
    logic          cmd_valid;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [AW-1:0] cmd_data;
    logic          cmd_ready;
    logic          rsp_valid;
    logic [AW-1:0] rsp_data;
    logic          rsp_error;
    logic          m_wr_access;
    logic [PW-1:0] m_wr_packet;
    logic          m_wr_wait;
    logic          m_rd_access;
    logic [PW-1:0] m_rd_packet;
    logic          m_rd_wait;
    logic          m_rr_access;
    logic [PW-1:0] m_rr_packet;
    logic          m_rr_wait;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_error,
        output m_wr_access, m_wr_packet, input m_wr_wait,
        output m_rd_access, m_rd_packet, input m_rd_wait,
        input  m_rr_access, m_rr_packet, output m_rr_wait
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_error,
        input  m_wr_access, m_wr_packet, output m_wr_wait,
        input  m_rd_access, m_rd_packet, output m_rd_wait,
        output m_rr_access, m_rr_packet, input m_rr_wait
    );
endinterface

`default_nettype wire

// File: rtl/accel_driver_emesh2packet.sv
// ============================================================================
// Module      : emesh2packet
// Description : Packs emesh transaction fields into a flat packet word.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module emesh2packet
    import accel_driver_pkg::*;
#(
    parameter int AW = 32,
    parameter int PW = 2*AW+40
) (
    input  wire logic          write_in,
    input  wire logic [1:0]    datamode_in,
    input  wire logic [4:0]    ctrlmode_in,
    input  wire logic [AW-1:0] dstaddr_in,
    input  wire logic [AW-1:0] data_in,
    input  wire logic [AW-1:0] srcaddr_in,
    output logic      [PW-1:0] packet_out
);
    always_comb begin
        packet_out                           = '0;
        packet_out[PKT_WRITE_BIT]            = write_in;
        packet_out[PKT_DMODE_LSB +: 2]       = datamode_in;
        packet_out[PKT_CMODE_LSB +: 5]       = ctrlmode_in;
        packet_out[PKT_DST_LSB +: AW]        = dstaddr_in;
        packet_out[PKT_DATA_LSB +: AW]       = data_in;
        packet_out[PKT_SRC_LSB +: AW]        = srcaddr_in;
    end
endmodule

`default_nettype wire

// File: rtl/accel_driver.sv
// ============================================================================
// Module      : accel_driver
// Description : Single-outstanding command driver issuing emesh write/read
//               packets. Optional read timeout: ACCEL_DRIVER_TIMEOUT_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module accel_driver
    import accel_driver_pkg::*;
#(
    parameter int          AW      = 32,
    parameter int          PW      = 2*AW+40,
    parameter logic [11:0] ID      = 12'h810,
    parameter logic [15:0] TIMEOUT = 16'd1024
) (
    input  wire logic      clk,
    input  wire logic      reset,
    accel_driver_if.master bus
);
    state_e        state_q, state_d;
    logic          write_q, write_d;
    logic [1:0]    dmode_q, dmode_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic [AW-1:0] data_q,  data_d;
    logic [AW-1:0] src_q,   src_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [AW-1:0] rsp_data_q,  rsp_data_d;
    logic          rsp_error_d;
    logic [PW-1:0] w_packet;
`ifdef ACCEL_DRIVER_TIMEOUT_EN
    logic          rsp_error_q;
    logic [15:0]   cnt_q, cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        dmode_d     = dmode_q;
        addr_d      = addr_q;
        data_d      = data_q;
        src_d       = src_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = '0;
        rsp_error_d = 1'b0;
`ifdef ACCEL_DRIVER_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    // Packet fields are latched whole so the shared packet stays stable.
                    write_d = bus.cmd_write;
                    dmode_d = DATAMODE_WORD;
                    addr_d  = bus.cmd_addr;
                    data_d  = bus.cmd_write ? bus.cmd_data : '0;
                    src_d   = bus.cmd_write ? '0 : {ID, SRCADDR_LO};
                    state_d = bus.cmd_write ? ST_WR : ST_RD;
                end
            end
            ST_WR: begin
                if (!bus.m_wr_wait) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                end
            end
            ST_RD: begin
                if (!bus.m_rd_wait) begin
                    state_d = ST_RESP;
`ifdef ACCEL_DRIVER_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_RESP: begin
                // A response arriving on the timeout cycle still wins.
                if (bus.m_rr_access) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = bus.m_rr_packet[PKT_DATA_LSB +: AW];
                end
`ifdef ACCEL_DRIVER_TIMEOUT_EN
                else if (cnt_q == TIMEOUT - 16'd1) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            dmode_q     <= 2'b00;
            addr_q      <= '0;
            data_q      <= '0;
            src_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            dmode_q     <= dmode_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            src_q       <= src_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

`ifdef ACCEL_DRIVER_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            rsp_error_q <= rsp_error_d;
        end
    end
    assign bus.rsp_error = rsp_error_q;
`else
    assign bus.rsp_error = 1'b0;
`endif

    emesh2packet #(.AW(AW), .PW(PW)) u_e2p (
        .write_in    (write_q),
        .datamode_in (dmode_q),
        .ctrlmode_in (CTRLMODE_NONE),
        .dstaddr_in  (addr_q),
        .data_in     (data_q),
        .srcaddr_in  (src_q),
        .packet_out  (w_packet)
    );

    assign bus.cmd_ready   = (state_q == ST_IDLE);
    assign bus.m_wr_access = (state_q == ST_WR);
    assign bus.m_rd_access = (state_q == ST_RD);
    assign bus.m_wr_packet = w_packet;
    assign bus.m_rd_packet = w_packet;
    assign bus.m_rr_wait   = 1'b0;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;

endmodule

`default_nettype wire

// File: tb/tb_accel_driver.sv
// ============================================================================
// Module      : tb_accel_driver
// Description : Cycle-table bench for accel_driver; transactions expand into
//               per-cycle expectations derived from the protocol rules.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_accel_driver;
    localparam int          AW  = 32;
    localparam int          PW  = 104;
    localparam logic [11:0] ID  = 12'h810;
    localparam int          TMO = 16;
`ifdef ACCEL_DRIVER_TIMEOUT_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    accel_driver_if #(.AW(AW), .PW(PW)) bus ();

    accel_driver #(.AW(AW), .PW(PW), .ID(ID), .TIMEOUT(16'(TMO))) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic          cv, cw;
        logic [31:0]   ca, cd;
        logic          wrw, rdw, rra;
        logic [31:0]   rrd;
        logic          rdy, wr, rd, rv, re;
        logic [31:0]   rdat;
        logic [PW-1:0] pkt;
        logic          pin_pkt_en, pin_rsp_en;
        logic [PW-1:0] pin_pkt;
        logic [31:0]   pin_rsp;
    } item_t;

    item_t         q[$];
    logic [PW-1:0] g_pkt = '0;
    logic          g_pv = 1'b0, g_pe = 1'b0;
    logic [31:0]   g_pd = '0;
    int            last_busy, last_rsp;
    int            n_chk = 0, n_pass = 0;
    logic          run = 1'b0;
    int            cur = 0;

    function automatic logic [PW-1:0] pack(input logic w, input logic [31:0] a,
                                           input logic [31:0] d, input logic [31:0] s);
        return {s, d, a, 5'b0, 2'b10, w};
    endfunction

    task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (cycle item %0d): got %h want %h", nm, cur, act, exp);
    endtask

    task automatic push(input logic cv, input logic cw, input logic [31:0] ca,
                        input logic [31:0] cd, input logic wrw, input logic rdw,
                        input logic rra, input logic [31:0] rrd,
                        input logic rdy, input logic wr, input logic rd);
        item_t it;
        it.cv = cv; it.cw = cw; it.ca = ca; it.cd = cd;
        it.wrw = wrw; it.rdw = rdw; it.rra = rra; it.rrd = rrd;
        it.rdy = rdy; it.wr = wr; it.rd = rd;
        it.rv = g_pv; it.re = g_pe; it.rdat = g_pd; it.pkt = g_pkt;
        it.pin_pkt_en = 1'b0; it.pin_rsp_en = 1'b0; it.pin_pkt = '0; it.pin_rsp = '0;
        if (g_pv) last_rsp = q.size();
        q.push_back(it);
        g_pv = 1'b0; g_pe = 1'b0; g_pd = '0;
    endtask

    task automatic g_idle(input int n, input logic rra);
        for (int i = 0; i < n; i++) push(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, rra, 32'h0BAD_0BAD, 1'b1, 1'b0, 1'b0);
    endtask

    // Write: one accept cycle, w stalled + 1 completing access cycles, response next.
    task automatic g_write(input logic [31:0] a, input logic [31:0] d, input int w);
        push(1'b1, 1'b1, a, d, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        g_pkt = pack(1'b1, a, d, 32'h0);
        last_busy = q.size();
        for (int i = 0; i <= w; i++) push(1'b1, 1'b0, ~a, ~d, (i < w), 1'b0, 1'b1, 32'hBAD, 1'b0, 1'b1, 1'b0);
        g_pv = 1'b1; g_pd = '0; g_pe = 1'b0;
    endtask

    // Read: accept, w stalls, then the response after r idle wait cycles (or timeout).
    task automatic g_read(input logic [31:0] a, input int w, input int r, input logic [31:0] d);
        push(1'b1, 1'b0, a, 32'h5555_AAAA, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        g_pkt = pack(1'b0, a, 32'h0, {ID, 20'h0});
        last_busy = q.size();
        for (int i = 0; i <= w; i++) push(1'b1, 1'b1, ~a, 32'h1, 1'b0, (i < w), 1'b1, 32'hBAD, 1'b0, 1'b0, 1'b1);
        if (TEN && r >= TMO) begin
            for (int i = 0; i < TMO; i++) push(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
            g_pv = 1'b1; g_pe = 1'b1; g_pd = '0;
        end else begin
            for (int i = 0; i < r; i++) push(1'b1, 1'b1, 32'h9, 32'h9, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
            push(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0);
            g_pv = 1'b1; g_pd = d; g_pe = 1'b0;
        end
    endtask

    task automatic pin_pkt(input int idx, input logic [PW-1:0] p);
        item_t t = q[idx];
        t.pin_pkt_en = 1'b1; t.pin_pkt = p; q[idx] = t;
    endtask

    task automatic pin_rsp(input int idx, input logic [31:0] d);
        item_t t = q[idx];
        t.pin_rsp_en = 1'b1; t.pin_rsp = d; q[idx] = t;
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("ctl{rdy,wr,rd,rv,re,rrwait}",
                PW'({bus.cmd_ready, bus.m_wr_access, bus.m_rd_access, bus.rsp_valid, bus.rsp_error, bus.m_rr_wait}),
                PW'({q[cur].rdy, q[cur].wr, q[cur].rd, q[cur].rv, q[cur].re, 1'b0}));
            chk("rsp_data", PW'(bus.rsp_data), PW'(q[cur].rdat));
            chk("m_wr_packet", bus.m_wr_packet, q[cur].pkt);
            chk("m_rd_packet", bus.m_rd_packet, q[cur].pkt);
            if (q[cur].pin_pkt_en) chk("pinned_packet", bus.m_wr_packet, q[cur].pin_pkt);
            if (q[cur].pin_rsp_en) chk("pinned_rsp_data", PW'(bus.rsp_data), PW'(q[cur].pin_rsp));
        end
    end

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_data = '0;
        bus.m_wr_wait = 1'b0; bus.m_rd_wait = 1'b0; bus.m_rr_access = 1'b0; bus.m_rr_packet = '0;
        #1 reset = 1'b1;
        #1;
        chk("reset_ctl", PW'({bus.cmd_ready, bus.m_wr_access, bus.m_rd_access, bus.rsp_valid, bus.rsp_error}),
            PW'(5'b10000));
        chk("reset_rsp_data", PW'(bus.rsp_data), '0);
        chk("reset_packet", bus.m_wr_packet | bus.m_rd_packet, '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        g_idle(2, 1'b0);
        g_idle(1, 1'b1);
        g_write(32'h8100_0000, 32'h0000_1234, 0);
        pin_pkt(last_busy, 104'h00000000_00001234_81000000_05);
        g_read(32'h8100_0008, 3, 2, 32'h0000_0007);
        pin_pkt(last_busy, 104'h81000000_00000000_81000008_04);
        g_write(32'h0000_0FFC, 32'hFFFF_FFFF, 2);
        pin_rsp(last_rsp, 32'h0000_0007);
        g_read(32'hFFFF_FFFC, 0, 0, 32'h8000_0001);
        g_read(32'h1234_5678, 1, 40, 32'hCAFE_F00D);
        g_idle(5, 1'b0);
        g_idle(3, 1'b1);
        if (TEN) g_read(32'h0000_0040, 0, TMO - 1, 32'h0000_0055);
        g_idle(3, 1'b0);

        for (int i = 0; i < q.size(); i++) begin
            @(posedge clk);
            #1;
            bus.cmd_valid   = q[i].cv;
            bus.cmd_write   = q[i].cw;
            bus.cmd_addr    = q[i].ca;
            bus.cmd_data    = q[i].cd;
            bus.m_wr_wait   = q[i].wrw;
            bus.m_rd_wait   = q[i].rdw;
            bus.m_rr_access = q[i].rra;
            bus.m_rr_packet = {32'hA5A5_5A5A, q[i].rrd, 32'hFFFF_FFFF, 8'hFF};
            cur = i;
            run = 1'b1;
        end
        @(posedge clk);
        #1 run = 1'b0;
        bus.m_rr_access = 1'b0;

        // Reset while a read is stalled in the request phase.
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h8100_0010; bus.m_rd_wait = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(posedge clk);
        #1 chk("pre_reset_rd_access", PW'(bus.m_rd_access), PW'(1'b1));
        #2 reset = 1'b1;
        #1;
        chk("async_reset_ctl", PW'({bus.cmd_ready, bus.m_wr_access, bus.m_rd_access, bus.rsp_valid}),
            PW'(4'b1000));
        chk("async_reset_packet", bus.m_rd_packet, '0);
        @(negedge clk);
        reset = 1'b0;
        bus.m_rd_wait = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_reset_quiet", PW'({bus.cmd_ready, bus.m_rd_access, bus.rsp_valid}), PW'(3'b100));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
